// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: runtime-programmable serial pattern detector with saturating match counter.
// Define SEQ_PATTERN_MASK_EN to add a per-bit don't-care mask captured alongside the pattern.
module seq_pattern_detector #(
    parameter int unsigned      PAT_W           = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PATTERN = PAT_W'(4'b1001),
    parameter int unsigned      CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic [PAT_W-1:0] pattern_in,
`ifdef SEQ_PATTERN_MASK_EN
    input  logic [PAT_W-1:0] pattern_mask_in,
`endif
    input  logic             pattern_load,
    input  logic             overlap_en,
    input  logic             count_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int unsigned      FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [PAT_W-1:0]  history_q, history_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sat_q;

    logic [PAT_W-1:0]  hist_n;
    logic [PAT_W-1:0]  diff;
    logic [FILL_W-1:0] fill_n;
    logic              hit;

`ifdef SEQ_PATTERN_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pattern_q <= DEFAULT_PATTERN;
            history_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
`ifdef SEQ_PATTERN_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            pattern_q <= pattern_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            count_q   <= count_d;
            sat_q     <= &count_d;
`ifdef SEQ_PATTERN_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    always_comb begin
        hist_n = {history_q[PAT_W-2:0], x};
        fill_n = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
        diff   = hist_n ^ pattern_q;
`ifdef SEQ_PATTERN_MASK_EN
        diff   = diff & mask_q;
`endif
        hit    = (fill_n == FULL) && (diff == '0);
    end

    always_comb begin
        pattern_d = pattern_q;
        history_d = history_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        count_d   = count_q;
`ifdef SEQ_PATTERN_MASK_EN
        mask_d    = mask_q;
`endif
        if (pattern_load) begin
            pattern_d = pattern_in;
            fill_d    = '0;
`ifdef SEQ_PATTERN_MASK_EN
            mask_d    = pattern_mask_in;
`endif
        end else if (x_valid) begin
            history_d = hist_n;
            if (hit) begin
                match_d = 1'b1;
                fill_d  = overlap_en ? FULL : '0;
                if (!(&count_q))
                    count_d = count_q + CNT_W'(1);
            end else begin
                fill_d = fill_n;
            end
        end
        // Clear wins over a same-cycle increment; the match pulse is unaffected.
        if (count_clr)
            count_d = '0;
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign count_sat   = sat_q;

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed 4-bit "1001" detector FSM. It detects a runtime-programmable PAT_W-bit pattern in a serial stream with valid qualification and a selectable overlapping or non-overlapping mode. It also keeps a saturating match counter. It sits after the serial input synchroniser and drives control/status logic.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
DEFAULT_PATTERN, 4'b1001, pattern loaded at reset (PAT_W bits; MSB is the oldest bit).
CNT_W, 8, match counter width; legal range >= 2.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
x  input  1  serial data bit.
x_valid  input  1  x is sampled this cycle when high.
pattern_in  input  PAT_W  new pattern; MSB = first bit received.
pattern_load  input  1  load pattern_in this cycle.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
count_clr  input  1  clear match_count.
match  output  1  registered, one-cycle pulse per detected pattern.
match_count  output  CNT_W  saturating count of matches.
count_sat  output  1  high while match_count is all ones.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clock. On reset:
  - pattern reg = DEFAULT_PATTERN
  - history = 0, fill = 0
  - match = 0, match_count = 0, count_sat = 0
- State held in registers:
  - history[PAT_W-1:0]: shift register of received bits, newest in the LSB.
  - fill: 0..PAT_W, the number of valid history bits.
- Accepting a bit (x_valid=1, pattern_load=0, reset=0):
  - hist_n = {history[PAT_W-2:0], x}
  - fill_n = min(fill+1, PAT_W)
  - hit = (fill_n == PAT_W) && (hist_n == pattern)
- Latency: match is registered on the same edge that samples the completing bit. It is high for exactly the following cycle, i.e. one cycle of latency, Moore style.
- If hit and overlap_en=1: history = hist_n and fill = PAT_W. Any suffix of the pattern that is also a prefix can contribute to the next match.
- If hit and overlap_en=0: fill = 0. The next match needs PAT_W fresh bits.
- If no hit: history = hist_n, fill = fill_n.
- When x_valid=0: history and fill hold, and match = 0. Gaps in valid never break a sequence.
- pattern_load=1 (has priority over x_valid):
  - pattern reg = pattern_in, fill = 0, match = 0.
  - x is ignored that cycle.
  - match_count is not affected.
- overlap_en is sampled each accepted bit. Changing it mid-stream affects only the next hit.
- match_count:
  - Increments by 1 on each hit.
  - Holds at 2^CNT_W-1 (no wrap).
  - count_sat = (match_count == all ones), registered alongside the count.
- count_clr: match_count = 0 and count_sat = 0. If count_clr and a hit occur in the same cycle, the clear wins (count = 0) but match still pulses.
- Priority, highest first: reset > pattern_load > x_valid path.
- Reset mid-sequence discards the partial sequence and restores DEFAULT_PATTERN.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEQ_PATTERN_MASK_EN.
- When defined:
  - Adds input pattern_mask_in [PAT_W-1:0], captured into a mask reg on pattern_load.
  - Reset value of the mask is all ones.
  - hit = (fill_n == PAT_W) && (((hist_n ^ pattern) & mask) == 0). Mask bit 0 = don't-care position.
- When not defined: the port and register are absent, and all PAT_W bits are compared exactly.

Test Plan:
1. Reset, default pattern 1001, overlap_en=1, x_valid=1, stream 1,0,0,1 -> match=1 only in the cycle after the 4th bit; match_count=1; count_sat=0.
2. Load 101 with PAT_W=3 build, overlap_en=1, stream 1,0,1,0,1 -> match after bits 3 and 5, count=2. Repeat with overlap_en=0 -> match after bit 3 only, count=1.
3. Default 1001, stream 1,0, x_valid low 3 cycles, then 0,1 -> match after the final bit; match=0 throughout the gap cycles.
4. CNT_W=2, six 1001 matches -> match_count=3 with count_sat=1 after the 3rd match. Then count_clr asserted in the same cycle as a hit -> count=0, match pulses.
5. Stream 1,0,0, then reset one cycle, then 1 -> no match; pattern reads back as 1001 (detected only after a full 1,0,0,1).
6. Stream 1,0,0 with pattern 1001, then pattern_load=1 with pattern_in=0110 while x_valid=1, x=1 -> no match, fill cleared. Then stream 0,1,1,0 -> match after the 4th bit.
